// File: rtl/motion_stats.sv
// motion_stats: zero-latency pixel pass-through plus per-frame motion count / bounding-box record.
// Optional macro MOTION_STATS_FRAME_CNT_EN puts a wrapping 3-bit frame counter in stat_din[63:61].
module motion_stats #(
    parameter int                    DATA_WIDTH    = 24,
    parameter int                    IMG_WIDTH     = 720,
    parameter int                    IMG_HEIGHT    = 540,
    parameter logic [DATA_WIDTH-1:0] HIGHLIGHT     = 24'hFF0000,
    parameter logic [19:0]           MOTION_THRESH = 20'd100
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  stat_wr_en,
    input  logic                  stat_full,
    output logic [63:0]           stat_din
);

    typedef enum logic {
        S_PIXEL  = 1'b0,
        S_REPORT = 1'b1
    } state_t;

    localparam logic [9:0] LAST_COL = 10'(IMG_WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMG_HEIGHT - 1);

    state_t      r_state;
    logic [9:0]  r_col;
    logic [9:0]  r_row;
    logic [19:0] r_count;
    logic [9:0]  r_min_x;
    logic [9:0]  r_max_x;
    logic [9:0]  r_min_y;
    logic [9:0]  r_max_y;
    logic [63:0] r_record;

    logic        w_xfer;
    logic        w_push;
    logic        w_hit;
    logic        w_eol;
    logic        w_eof;
    logic [19:0] w_count_nxt;
    logic [9:0]  w_min_x_nxt;
    logic [9:0]  w_max_x_nxt;
    logic [9:0]  w_min_y_nxt;
    logic [9:0]  w_max_y_nxt;
    logic [2:0]  w_frame_id;

    // Handshakes are gated by reset so they drop the instant reset asserts.
    assign w_xfer = reset && (r_state == S_PIXEL) && !in_empty && !out_full;
    assign w_push = reset && (r_state == S_REPORT) && !stat_full;

    assign in_rd_en   = w_xfer;
    assign out_wr_en  = w_xfer;
    assign out_din    = in_dout;
    assign stat_wr_en = w_push;
    assign stat_din   = r_record;

    assign w_hit = (in_dout == HIGHLIGHT);
    assign w_eol = (r_col == LAST_COL);
    assign w_eof = w_eol && (r_row == LAST_ROW);

    always_comb begin
        w_count_nxt = r_count;
        w_min_x_nxt = r_min_x;
        w_max_x_nxt = r_max_x;
        w_min_y_nxt = r_min_y;
        w_max_y_nxt = r_max_y;
        if (w_hit) begin
            if (r_count != 20'hFFFFF) w_count_nxt = r_count + 20'd1;
            if (r_col < r_min_x) w_min_x_nxt = r_col;
            if (r_col > r_max_x) w_max_x_nxt = r_col;
            if (r_row < r_min_y) w_min_y_nxt = r_row;
            if (r_row > r_max_y) w_max_y_nxt = r_row;
        end
    end

`ifdef MOTION_STATS_FRAME_CNT_EN
    logic [2:0] r_frame_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= 3'd0;
        end else if (w_push) begin
            r_frame_cnt <= r_frame_cnt + 3'd1;
        end
    end

    assign w_frame_id = r_frame_cnt;
`else
    assign w_frame_id = 3'd0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_PIXEL;
            r_col    <= 10'd0;
            r_row    <= 10'd0;
            r_count  <= 20'd0;
            r_min_x  <= 10'h3FF;
            r_max_x  <= 10'd0;
            r_min_y  <= 10'h3FF;
            r_max_y  <= 10'd0;
            r_record <= 64'd0;
        end else begin
            case (r_state)
                S_PIXEL: begin
                    if (w_xfer) begin
                        r_count <= w_count_nxt;
                        r_min_x <= w_min_x_nxt;
                        r_max_x <= w_max_x_nxt;
                        r_min_y <= w_min_y_nxt;
                        r_max_y <= w_max_y_nxt;
                        if (w_eol) begin
                            r_col <= 10'd0;
                            r_row <= w_eof ? 10'd0 : r_row + 10'd1;
                        end else begin
                            r_col <= r_col + 10'd1;
                        end
                        // Record is built from the next-state values so the last pixel counts.
                        if (w_eof) begin
                            r_record <= {w_frame_id,
                                         (w_count_nxt >= MOTION_THRESH),
                                         w_count_nxt,
                                         w_min_x_nxt, w_max_x_nxt,
                                         w_min_y_nxt, w_max_y_nxt};
                            r_state  <= S_REPORT;
                        end
                    end
                end
                S_REPORT: begin
                    if (w_push) begin
                        r_count <= 20'd0;
                        r_min_x <= 10'h3FF;
                        r_max_x <= 10'd0;
                        r_min_y <= 10'h3FF;
                        r_max_y <= 10'd0;
                        r_state <= S_PIXEL;
                    end
                end
                default: r_state <= S_PIXEL;
            endcase
        end
    end

endmodule
